// File: rtl/ppu_config_seq.sv
// ppu_config_seq: loads a small configuration table into the PPU over a
// strobe/ack handshake, then accepts PPU pixel data and forwards it as
// colour channels to the VGA driver.
//
// Ports:
//   clk_pix, sim_rst                   pixel clock, async active-high reset
//   cfg_we/cfg_addr/cfg_wdata          configuration table write port
//   cfg_len, mode_in                   words to send and mode latched on start
//   start, reload, frame_start         sequence triggers
//   de                                 data enable from VGA timing
//   ppu_sync, ppu_mode                 load-in-progress flag, latched mode
//   ppu_data_i, ppu_stb_i, ppu_ack_i   config word handshake towards the PPU
//   ppu_data_o, ppu_stb_o, ppu_ack_o   pixel data handshake from the PPU
//   pix_r, pix_g, pix_b                colour to VGA driver
//   busy, err                          SEND in progress, sticky ack timeout
module ppu_config_seq #(
    parameter int unsigned CORDW           = 10,
    parameter int unsigned DW              = 8,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned MODEW           = 3,
    parameter int unsigned CHW             = 2,
    parameter int unsigned TIMEOUT         = 255,
    parameter bit          RELOAD_ON_FRAME = 1'b0
) (
    input  logic                       clk_pix,
    input  logic                       sim_rst,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [DW-1:0]              cfg_wdata,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic [MODEW-1:0]           mode_in,
    input  logic                       start,
    input  logic                       reload,
    input  logic                       frame_start,
    input  logic                       de,
    output logic                       ppu_sync,
    output logic [MODEW-1:0]           ppu_mode,
    output logic [DW-1:0]              ppu_data_i,
    output logic                       ppu_stb_i,
    input  logic                       ppu_ack_i,
    input  logic [DW-1:0]              ppu_data_o,
    input  logic                       ppu_stb_o,
    output logic                       ppu_ack_o,
    output logic [CHW-1:0]             pix_r,
    output logic [CHW-1:0]             pix_g,
    output logic [CHW-1:0]             pix_b,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = 3 * CHW;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    // Coordinate width is part of the shared parameter set but unused here.
    localparam int unsigned cordw_unused = CORDW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_RUN   = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [LW-1:0]         len_q, len_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [MODEW-1:0]      mode_q, mode_d;
    logic                  err_q, err_d;
    logic [PW-1:0]         pix_q, pix_d;
    logic [DW-1:0]         data_q, data_d;
    logic                  stb_q, stb_d;
    logic                  sync_q, sync_d;
    logic                  ack_o_q, ack_o_d;
    logic                  busy_q, busy_d;
    logic [CHW-1:0]        r_q, r_d, g_q, g_d, b_q, b_d;

    logic [DW-1:0]         mem_q [DEPTH];
    logic                  addr_ok_c;
    logic [LW-1:0]         len_start_c;
    logic                  reload_c;
    logic [DW-1:0]         data_o_unused;

    // Only the top 3*CHW bits of the PPU pixel word carry colour.
    assign data_o_unused = ppu_data_o;

    // Out-of-range addresses are only possible for non-power-of-two depths.
    if (DEPTH == (1 << AW)) begin : g_addr_pow2
        assign addr_ok_c = 1'b1;
    end else begin : g_addr_range
        assign addr_ok_c = ({1'b0, cfg_addr} < LW'(DEPTH));
    end

    assign len_start_c = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
    assign reload_c    = reload || (RELOAD_ON_FRAME && frame_start);

    // Config table; contents are not reset. Frozen while words are being sent.
    always_ff @(posedge clk_pix) begin
        if (cfg_we && addr_ok_c && (state_q != S_SEND)) begin
            mem_q[cfg_addr] <= cfg_wdata;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_pix or posedge sim_rst) begin
        if (sim_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            wait_q  <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
            pix_q   <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            sync_q  <= 1'b0;
            ack_o_q <= 1'b0;
            busy_q  <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            wait_q  <= wait_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            pix_q   <= pix_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            sync_q  <= sync_d;
            ack_o_q <= ack_o_d;
            busy_q  <= busy_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        wait_d  = wait_q;
        mode_d  = mode_q;
        err_d   = err_q;
        pix_d   = pix_q;

        unique case (state_q)
            S_IDLE, S_ERROR, S_RUN: begin
                if (start) begin
                    mode_d  = mode_in;
                    len_d   = len_start_c;
                    idx_d   = '0;
                    wait_d  = '0;
                    err_d   = 1'b0;
                    state_d = (len_start_c != '0) ? S_SEND : S_RUN;
                end else if ((state_q == S_RUN) && reload_c && (len_q != '0)) begin
                    idx_d   = '0;
                    wait_d  = '0;
                    state_d = S_SEND;
                end
                if ((state_q == S_RUN) && ppu_stb_o) begin
                    pix_d = ppu_data_o[DW-1 -: PW];
                end
            end
            S_SEND: begin
                if (ppu_ack_i) begin
                    wait_d = '0;
                    if ({1'b0, idx_q} == (len_q - LW'(1))) begin
                        idx_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    wait_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Present the next word one cycle ahead so data and strobe register together.
        data_d  = (state_d == S_SEND) ? mem_q[idx_d] : data_q;
        stb_d   = (state_d == S_SEND);
        sync_d  = (state_d == S_SEND);
        busy_d  = (state_d == S_SEND);
        ack_o_d = (state_d == S_RUN);

        // Colour gated by de one cycle later; blank outside RUN/SEND.
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de && ((state_q == S_RUN) || (state_q == S_SEND))) begin
            r_d = pix_q[PW-1 -: CHW];
            g_d = pix_q[2*CHW-1 -: CHW];
            b_d = pix_q[CHW-1:0];
        end
    end

    assign ppu_sync   = sync_q;
    assign ppu_mode   = mode_q;
    assign ppu_data_i = data_q;
    assign ppu_stb_i  = stb_q;
    assign ppu_ack_o  = ack_o_q;
    assign pix_r      = r_q;
    assign pix_g      = g_q;
    assign pix_b      = b_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ppu_config_seq.sv
module tb_ppu_config_seq;

    localparam int DEPTH   = 16;
    localparam int DW      = 8;
    localparam int MODEW   = 3;
    localparam int CHW     = 2;
    localparam int TIMEOUT = 20;

    logic             clk_pix = 1'b0;
    logic             sim_rst;
    logic             cfg_we;
    logic [3:0]       cfg_addr;
    logic [DW-1:0]    cfg_wdata;
    logic [4:0]       cfg_len;
    logic [MODEW-1:0] mode_in;
    logic             start, reload, frame_start, de;
    logic             ppu_sync;
    logic [MODEW-1:0] ppu_mode;
    logic [DW-1:0]    ppu_data_i;
    logic             ppu_stb_i;
    logic             ppu_ack_i;
    logic [DW-1:0]    ppu_data_o;
    logic             ppu_stb_o;
    logic             ppu_ack_o;
    logic [CHW-1:0]   pix_r, pix_g, pix_b;
    logic             busy, err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tbl [16];
    logic [7:0] acc_q [$];
    logic [7:0] seen_q [$];
    bit         ack_q [$];
    int         stb_cyc, sync_cyc;
    bit         send_to;

    ppu_config_seq #(
        .CORDW(10), .DW(DW), .DEPTH(DEPTH), .MODEW(MODEW), .CHW(CHW),
        .TIMEOUT(TIMEOUT), .RELOAD_ON_FRAME(1'b1)
    ) dut (
        .clk_pix(clk_pix), .sim_rst(sim_rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_len(cfg_len), .mode_in(mode_in),
        .start(start), .reload(reload), .frame_start(frame_start), .de(de),
        .ppu_sync(ppu_sync), .ppu_mode(ppu_mode),
        .ppu_data_i(ppu_data_i), .ppu_stb_i(ppu_stb_i), .ppu_ack_i(ppu_ack_i),
        .ppu_data_o(ppu_data_o), .ppu_stb_o(ppu_stb_o), .ppu_ack_o(ppu_ack_o),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .busy(busy), .err(err)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic load_table();
        for (int i = 0; i < 16; i++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 4'(i);
            cfg_wdata = tbl[i];
            step();
        end
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int len, input int mode);
        cfg_len = 5'(len);
        mode_in = 3'(mode);
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Drives ack (period 0 = never) while busy and records the handshake.
    task automatic run_send(input int ack_period);
        bit ackv;
        acc_q.delete();
        seen_q.delete();
        ack_q.delete();
        stb_cyc  = 0;
        sync_cyc = 0;
        send_to  = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (!busy) begin
                send_to = 1'b0;
                break;
            end
            if (ppu_sync) sync_cyc++;
            if (ppu_stb_i) stb_cyc++;
            seen_q.push_back(ppu_data_i);
            ackv = (ack_period == 0) ? 1'b0 : ((c % ack_period) == ack_period - 1);
            ppu_ack_i = ackv;
            ack_q.push_back(ackv);
            if (ackv && ppu_stb_i) acc_q.push_back(ppu_data_i);
            step();
        end
        ppu_ack_i = (ack_period != 0);
    endtask

    task automatic test_reset();
        sim_rst = 1'b1;
        step();
        step();
        checks++;
        if ({ppu_sync, ppu_stb_i, ppu_ack_o, busy, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {ppu_sync, ppu_stb_i, ppu_ack_o, busy, err});
        end
        checks++;
        if ({ppu_mode, ppu_data_i, pix_r, pix_g, pix_b} !== 17'b0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {ppu_mode, ppu_data_i, pix_r, pix_g, pix_b});
        end
        sim_rst = 1'b0;
        step();
    endtask

    task automatic test_full_load();
        load_table();
        ppu_ack_i = 1'b1;
        do_start(10, 5);
        run_send(1);
        checks++;
        if (send_to !== 1'b0) begin failures++; $display("FAIL full_timeout got=%0d exp=0", send_to); end
        checks++;
        if (acc_q.size() != 10) begin failures++; $display("FAIL full_count got=%0d exp=10", acc_q.size()); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (acc_q[i] !== tbl[i]) begin
                failures++;
                $display("FAIL full_word%0d got=%h exp=%h", i, acc_q[i], tbl[i]);
            end
        end
        checks++;
        if (stb_cyc != 10) begin failures++; $display("FAIL full_stb_cycles got=%0d exp=10", stb_cyc); end
        checks++;
        if (sync_cyc != 10) begin failures++; $display("FAIL full_sync_cycles got=%0d exp=10", sync_cyc); end
        checks++;
        if ({ppu_sync, ppu_stb_i, ppu_ack_o, err} !== 4'b0010) begin
            failures++;
            $display("FAIL full_run_flags got=%b exp=0010", {ppu_sync, ppu_stb_i, ppu_ack_o, err});
        end
        checks++;
        if (ppu_mode !== 3'd5) begin failures++; $display("FAIL full_mode got=%0d exp=5", ppu_mode); end
    endtask

    task automatic test_ack_every3();
        int unstable;
        do_start(10, 2);
        run_send(3);
        checks++;
        if (acc_q.size() != 10) begin failures++; $display("FAIL slow_count got=%0d exp=10", acc_q.size()); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (acc_q[i] !== tbl[i]) begin
                failures++;
                $display("FAIL slow_word%0d got=%h exp=%h", i, acc_q[i], tbl[i]);
            end
        end
        unstable = 0;
        for (int i = 1; i < seen_q.size(); i++) begin
            if (!ack_q[i-1] && (seen_q[i] !== seen_q[i-1])) unstable++;
        end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL slow_stable got=%0d exp=0", unstable); end
        checks++;
        if (stb_cyc != 30) begin failures++; $display("FAIL slow_stb_cycles got=%0d exp=30", stb_cyc); end
        checks++;
        if (ppu_mode !== 3'd2) begin failures++; $display("FAIL slow_mode got=%0d exp=2", ppu_mode); end
    endtask

    task automatic test_timeout();
        do_start(10, 4);
        run_send(0);
        checks++;
        if (stb_cyc != TIMEOUT) begin failures++; $display("FAIL to_stb_cycles got=%0d exp=%0d", stb_cyc, TIMEOUT); end
        checks++;
        if ({err, ppu_stb_i, ppu_sync, busy, ppu_ack_o} !== 5'b10000) begin
            failures++;
            $display("FAIL to_flags got=%b exp=10000", {err, ppu_stb_i, ppu_sync, busy, ppu_ack_o});
        end
        ppu_ack_i   = 1'b1;
        reload      = 1'b1;
        frame_start = 1'b1;
        step();
        reload      = 1'b0;
        frame_start = 1'b0;
        step();
        checks++;
        if ({err, busy, ppu_stb_i} !== 3'b100) begin
            failures++;
            $display("FAIL to_hold got=%b exp=100", {err, busy, ppu_stb_i});
        end
        do_start(10, 5);
        checks++;
        if ({err, busy} !== 2'b01) begin failures++; $display("FAIL to_restart got=%b exp=01", {err, busy}); end
        run_send(1);
        checks++;
        if (acc_q.size() != 10) begin failures++; $display("FAIL to_resend_count got=%0d exp=10", acc_q.size()); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (acc_q[i] !== tbl[i]) begin
                failures++;
                $display("FAIL to_resend_word%0d got=%h exp=%h", i, acc_q[i], tbl[i]);
            end
        end
    endtask

    task automatic test_pixels();
        de = 1'b1; ppu_data_o = 8'hE4; ppu_stb_o = 1'b1;
        step();
        ppu_stb_o = 1'b0;
        step();
        checks++;
        if ({pix_r, pix_g, pix_b} !== {2'd3, 2'd2, 2'd1}) begin
            failures++;
            $display("FAIL pix_e4 got=%0d,%0d,%0d exp=3,2,1", pix_r, pix_g, pix_b);
        end
        de = 1'b0;
        step();
        checks++;
        if ({pix_r, pix_g, pix_b} !== 6'b0) begin
            failures++;
            $display("FAIL pix_blank got=%0d,%0d,%0d exp=0,0,0", pix_r, pix_g, pix_b);
        end
        de = 1'b1; ppu_data_o = 8'h1B; ppu_stb_o = 1'b1;
        step();
        ppu_data_o = 8'hFF; ppu_stb_o = 1'b0;
        step();
        checks++;
        if ({pix_r, pix_g, pix_b} !== {2'd0, 2'd1, 2'd2}) begin
            failures++;
            $display("FAIL pix_1b got=%0d,%0d,%0d exp=0,1,2", pix_r, pix_g, pix_b);
        end
        step();
        checks++;
        if ({pix_r, pix_g, pix_b} !== {2'd0, 2'd1, 2'd2}) begin
            failures++;
            $display("FAIL pix_hold got=%0d,%0d,%0d exp=0,1,2", pix_r, pix_g, pix_b);
        end
        de = 1'b0;
    endtask

    task automatic test_frame_reload();
        ppu_ack_i   = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if ({busy, ppu_ack_o, ppu_data_i} !== {2'b10, tbl[0]}) begin
            failures++;
            $display("FAIL frame_enter got=%h exp=%h", {busy, ppu_ack_o, ppu_data_i}, {2'b10, tbl[0]});
        end
        run_send(1);
        checks++;
        if (acc_q.size() != 10) begin failures++; $display("FAIL frame_count got=%0d exp=10", acc_q.size()); end
        checks++;
        if ({acc_q[0], acc_q[9]} !== {tbl[0], tbl[9]}) begin
            failures++;
            $display("FAIL frame_words got=%h exp=%h", {acc_q[0], acc_q[9]}, {tbl[0], tbl[9]});
        end
        // start wins over reload on the same cycle
        reload = 1'b1;
        do_start(3, 6);
        reload = 1'b0;
        run_send(1);
        checks++;
        if (acc_q.size() != 3) begin failures++; $display("FAIL prio_count got=%0d exp=3", acc_q.size()); end
        checks++;
        if (ppu_mode !== 3'd6) begin failures++; $display("FAIL prio_mode got=%0d exp=6", ppu_mode); end
        // length clamps to table depth
        do_start(20, 1);
        run_send(1);
        checks++;
        if (acc_q.size() != 16) begin failures++; $display("FAIL clamp_count got=%0d exp=16", acc_q.size()); end
        checks++;
        if (acc_q[15] !== tbl[15]) begin failures++; $display("FAIL clamp_last got=%h exp=%h", acc_q[15], tbl[15]); end
        // zero length goes straight to RUN
        do_start(0, 7);
        checks++;
        if ({busy, ppu_stb_i, ppu_sync, ppu_ack_o, ppu_mode} !== {4'b0001, 3'd7}) begin
            failures++;
            $display("FAIL zero_len got=%b exp=0001111", {busy, ppu_stb_i, ppu_sync, ppu_ack_o, ppu_mode});
        end
        reload = 1'b1;
        step();
        reload = 1'b0;
        step();
        checks++;
        if ({busy, ppu_stb_i} !== 2'b00) begin
            failures++;
            $display("FAIL zero_reload got=%b exp=00", {busy, ppu_stb_i});
        end
    endtask

    task automatic test_write_drop();
        ppu_ack_i = 1'b0;
        do_start(4, 1);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 8'h99;
        mode_in = 3'd3; start = 1'b1;
        step();
        cfg_we = 1'b0; start = 1'b0;
        step();
        checks++;
        if ({busy, ppu_mode, ppu_data_i} !== {1'b1, 3'd1, tbl[0]}) begin
            failures++;
            $display("FAIL send_ignore got=%h exp=%h", {busy, ppu_mode, ppu_data_i}, {1'b1, 3'd1, tbl[0]});
        end
        run_send(1);
        checks++;
        if (acc_q[0] !== tbl[0]) begin failures++; $display("FAIL write_dropped got=%h exp=%h", acc_q[0], tbl[0]); end
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 8'h99;
        step();
        cfg_we = 1'b0;
        do_start(1, 1);
        run_send(1);
        checks++;
        if (acc_q[0] !== 8'h99) begin failures++; $display("FAIL write_run got=%h exp=99", acc_q[0]); end
    endtask

    task automatic test_reset_mid_send();
        load_table();
        ppu_ack_i = 1'b1;
        do_start(10, 5);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (ppu_data_i !== tbl[4]) begin failures++; $display("FAIL mid_word4 got=%h exp=%h", ppu_data_i, tbl[4]); end
        sim_rst = 1'b1;
        #1;
        checks++;
        if ({ppu_sync, ppu_stb_i, ppu_ack_o, busy, err} !== 5'b0) begin
            failures++;
            $display("FAIL mid_rst_flags got=%b exp=00000", {ppu_sync, ppu_stb_i, ppu_ack_o, busy, err});
        end
        checks++;
        if ({ppu_mode, ppu_data_i, pix_r, pix_g, pix_b} !== 17'b0) begin
            failures++;
            $display("FAIL mid_rst_data got=%h exp=0", {ppu_mode, ppu_data_i, pix_r, pix_g, pix_b});
        end
        step();
        sim_rst = 1'b0;
        step();
        load_table();
        do_start(10, 5);
        run_send(1);
        checks++;
        if (acc_q.size() != 10) begin failures++; $display("FAIL mid_resend_count got=%0d exp=10", acc_q.size()); end
        checks++;
        if ({acc_q[0], acc_q[4], acc_q[9]} !== {tbl[0], tbl[4], tbl[9]}) begin
            failures++;
            $display("FAIL mid_resend_words got=%h exp=%h", {acc_q[0], acc_q[4], acc_q[9]}, {tbl[0], tbl[4], tbl[9]});
        end
    endtask

    initial begin
        tbl[0] = 8'd42;   tbl[1] = 8'd123; tbl[2] = 8'd87;  tbl[3] = 8'd255;
        tbl[4] = 8'd0;    tbl[5] = 8'd198; tbl[6] = 8'd76;  tbl[7] = 8'd34;
        tbl[8] = 8'd210;  tbl[9] = 8'hB6;  tbl[10] = 8'h11; tbl[11] = 8'h22;
        tbl[12] = 8'h33;  tbl[13] = 8'h44; tbl[14] = 8'h55; tbl[15] = 8'h66;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_len = '0; mode_in = '0;
        start = 1'b0; reload = 1'b0; frame_start = 1'b0; de = 1'b0;
        ppu_ack_i = 1'b0; ppu_data_o = '0; ppu_stb_o = 1'b0;

        test_reset();
        test_full_load();
        test_ack_every3();
        test_timeout();
        test_pixels();
        test_frame_reload();
        test_write_drop();
        test_reset_mid_send();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
